// File: rtl/rv_pipe_control.sv
// rtl/rv_pipe_control.sv - pipelined RV32I control unit: decode, ID/EX..MEM/WB control bundles, Execute branch resolution
// Optional feature macro: RV_CTRL_ILLEGAL_EN (illegal-instruction bit carried to W, exposed on illegal_w).

module rv_pipe_control #(
    parameter int EXTRA_MEM_STAGES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic        flush_e,
    input  logic        zero_e,
    input  logic        less_than_e,
    input  logic        less_than_u_e,
    output logic [2:0]  imm_src_d,
    output logic [3:0]  alu_control_e,
    output logic [1:0]  alu_src_a_e,
    output logic        alu_src_b_e,
    output logic [1:0]  pc_src_e,
    output logic        reg_write_e,
    output logic [1:0]  result_src_e,
    output logic [4:0]  rd_e,
    output logic        mem_write_m,
    output logic [2:0]  funct3_m,
    output logic        reg_write_m,
    output logic [4:0]  rd_m,
    output logic        reg_write_w,
    output logic [1:0]  result_src_w,
    output logic [4:0]  rd_w
`ifdef RV_CTRL_ILLEGAL_EN
    ,
    output logic        illegal_w
`endif
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    // Full control bundle held in ID/EX
    typedef struct packed {
`ifdef RV_CTRL_ILLEGAL_EN
        logic       illegal;
`endif
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic [2:0] funct3;
        logic [3:0] alu_control;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [4:0] rd;
    } ctrl_t;

    // Writeback-side fields, the only part that travels past EX/MEM
    typedef struct packed {
`ifdef RV_CTRL_ILLEGAL_EN
        logic       illegal;
`endif
        logic       reg_write;
        logic [1:0] result_src;
        logic [4:0] rd;
    } wb_t;

    typedef struct packed {
        logic       mem_write;
        logic [2:0] funct3;
        wb_t        wb;
    } mem_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign funct7 = instr_d[31:25];
    // Register specifiers rs1/rs2 are the datapath's business, not control's
    assign unused_instr_bits = ^instr_d[24:15];

    // ALU operation for OP / OP-IMM; alt selects sub (funct3 000) or sra (funct3 101)
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    ctrl_t dec_ctrl;
    logic  dec_legal;

    // Combinational decode of the Decode-stage instruction into a control bundle
    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b1;
        imm_src_d = IMM_I;
        case (opcode)
            OPC_LUI: begin
                imm_src_d             = IMM_U;
                dec_ctrl.reg_write    = 1'b1;
                dec_ctrl.alu_src_a    = SRC_A_ZERO;
                dec_ctrl.alu_src_b    = 1'b1;
                dec_ctrl.alu_control  = ALU_ADD;
            end
            OPC_AUIPC: begin
                imm_src_d             = IMM_U;
                dec_ctrl.reg_write    = 1'b1;
                dec_ctrl.alu_src_a    = SRC_A_PC;
                dec_ctrl.alu_src_b    = 1'b1;
                dec_ctrl.alu_control  = ALU_ADD;
            end
            OPC_JAL: begin
                imm_src_d             = IMM_J;
                dec_ctrl.reg_write    = 1'b1;
                dec_ctrl.result_src   = RES_PC4;
                dec_ctrl.jump         = 1'b1;
            end
            OPC_JALR: begin
                imm_src_d             = IMM_I;
                dec_ctrl.reg_write    = 1'b1;
                dec_ctrl.result_src   = RES_PC4;
                dec_ctrl.jalr         = 1'b1;
                dec_ctrl.alu_src_b    = 1'b1;
                dec_ctrl.alu_control  = ALU_ADD;
            end
            OPC_BRANCH: begin
                imm_src_d             = IMM_B;
                dec_legal             = (funct3[2:1] != 2'b01);
                dec_ctrl.branch       = 1'b1;
                dec_ctrl.funct3       = funct3;
                dec_ctrl.alu_control  = ALU_SUB;
            end
            OPC_LOAD: begin
                imm_src_d             = IMM_I;
                dec_ctrl.reg_write    = 1'b1;
                dec_ctrl.result_src   = RES_MEM;
                dec_ctrl.funct3       = funct3;
                dec_ctrl.alu_src_b    = 1'b1;
                dec_ctrl.alu_control  = ALU_ADD;
            end
            OPC_STORE: begin
                imm_src_d             = IMM_S;
                dec_ctrl.mem_write    = 1'b1;
                dec_ctrl.funct3       = funct3;
                dec_ctrl.alu_src_b    = 1'b1;
                dec_ctrl.alu_control  = ALU_ADD;
            end
            OPC_OP_IMM: begin
                imm_src_d             = IMM_I;
                dec_ctrl.reg_write    = 1'b1;
                dec_ctrl.result_src   = RES_ALU;
                dec_ctrl.alu_src_b    = 1'b1;
                dec_ctrl.alu_control  = alu_from_funct3(funct3, (funct3 == 3'b101) && instr_d[30]);
            end
            OPC_OP: begin
                dec_legal             = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                dec_ctrl.reg_write    = 1'b1;
                dec_ctrl.result_src   = RES_ALU;
                dec_ctrl.alu_control  = alu_from_funct3(funct3, instr_d[30]);
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
        // rd is only meaningful when the instruction writes; keep it 0 otherwise for the hazard unit
        dec_ctrl.rd = dec_ctrl.reg_write ? instr_d[11:7] : 5'd0;
        if (!dec_legal) begin
            dec_ctrl = '0;
        end
`ifdef RV_CTRL_ILLEGAL_EN
        dec_ctrl.illegal = ~dec_legal;
`endif
    end

    ctrl_t idex_d;
    ctrl_t idex_q;

    assign idex_d = flush_e ? ctrl_t'('0) : dec_ctrl;

    // ID/EX register; flush_e inserts a bubble, reset clears to a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    logic branch_taken;

    // Branch condition from the ALU flags, looked at only for a branch in Execute
    always_comb begin
        branch_taken = 1'b0;
        if (idex_q.branch) begin
            case (idex_q.funct3)
                3'b000:  branch_taken = zero_e;
                3'b001:  branch_taken = ~zero_e;
                3'b100:  branch_taken = less_than_e;
                3'b101:  branch_taken = ~less_than_e;
                3'b110:  branch_taken = less_than_u_e;
                3'b111:  branch_taken = ~less_than_u_e;
                default: branch_taken = 1'b0;
            endcase
        end
    end

    // Next-PC selection resolved in Execute
    always_comb begin
        pc_src_e = PC_SEQ;
        if (idex_q.jump) begin
            pc_src_e = PC_TARGET;
        end else if (idex_q.jalr) begin
            pc_src_e = PC_ALU;
        end else if (branch_taken) begin
            pc_src_e = PC_TARGET;
        end
    end

    assign alu_control_e = idex_q.alu_control;
    assign alu_src_a_e   = idex_q.alu_src_a;
    assign alu_src_b_e   = idex_q.alu_src_b;
    assign reg_write_e   = idex_q.reg_write;
    assign result_src_e  = idex_q.result_src;
    assign rd_e          = idex_q.rd;

    mem_t exmem_d;
    mem_t exmem_q;

    // Memory-stage slice of the Execute bundle
    always_comb begin
        exmem_d               = '0;
        exmem_d.mem_write     = idex_q.mem_write;
        exmem_d.funct3        = idex_q.funct3;
        exmem_d.wb.reg_write  = idex_q.reg_write;
        exmem_d.wb.result_src = idex_q.result_src;
        exmem_d.wb.rd         = idex_q.rd;
`ifdef RV_CTRL_ILLEGAL_EN
        exmem_d.wb.illegal    = idex_q.illegal;
`endif
    end

    // EX/MEM register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign mem_write_m = exmem_q.mem_write;
    assign funct3_m    = exmem_q.funct3;
    assign reg_write_m = exmem_q.wb.reg_write;
    assign rd_m        = exmem_q.wb.rd;

    // stage_wb[0] is the EX/MEM writeback slice; each extra stage adds one cycle of data-memory latency
    wb_t stage_wb [0:EXTRA_MEM_STAGES];

    assign stage_wb[0] = exmem_q.wb;

    for (genvar g = 0; g < EXTRA_MEM_STAGES; g++) begin : g_mem_delay
        wb_t dly_q;

        // Extra memory-latency delay register for the writeback fields
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dly_q <= '0;
            end else begin
                dly_q <= stage_wb[g];
            end
        end

        assign stage_wb[g+1] = dly_q;
    end

    wb_t memwb_q;

    // MEM/WB register fed from the end of the memory delay chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= stage_wb[EXTRA_MEM_STAGES];
        end
    end

    assign reg_write_w  = memwb_q.reg_write;
    assign result_src_w = memwb_q.result_src;
    assign rd_w         = memwb_q.rd;
`ifdef RV_CTRL_ILLEGAL_EN
    assign illegal_w    = memwb_q.illegal;
`endif

endmodule

// File: tb/tb_rv_pipe_control.sv
// tb/tb_rv_pipe_control.sv - randomized self-checking bench for rv_pipe_control (EXTRA_MEM_STAGES 0 and 2)

module tb_rv_pipe_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_d;
    logic        flush_e;
    logic        zero_e;
    logic        less_than_e;
    logic        less_than_u_e;

    logic [2:0] a_imm_src_d, b_imm_src_d;
    logic [3:0] a_alu_control_e, b_alu_control_e;
    logic [1:0] a_alu_src_a_e, b_alu_src_a_e;
    logic       a_alu_src_b_e, b_alu_src_b_e;
    logic [1:0] a_pc_src_e, b_pc_src_e;
    logic       a_reg_write_e, b_reg_write_e;
    logic [1:0] a_result_src_e, b_result_src_e;
    logic [4:0] a_rd_e, b_rd_e;
    logic       a_mem_write_m, b_mem_write_m;
    logic [2:0] a_funct3_m, b_funct3_m;
    logic       a_reg_write_m, b_reg_write_m;
    logic [4:0] a_rd_m, b_rd_m;
    logic       a_reg_write_w, b_reg_write_w;
    logic [1:0] a_result_src_w, b_result_src_w;
    logic [4:0] a_rd_w, b_rd_w;
`ifdef RV_CTRL_ILLEGAL_EN
    logic       a_illegal_w, b_illegal_w;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv_pipe_control #(.EXTRA_MEM_STAGES(0)) u_dut0 (
        .clk(clk), .reset(reset), .instr_d(instr_d), .flush_e(flush_e),
        .zero_e(zero_e), .less_than_e(less_than_e), .less_than_u_e(less_than_u_e),
        .imm_src_d(a_imm_src_d), .alu_control_e(a_alu_control_e), .alu_src_a_e(a_alu_src_a_e),
        .alu_src_b_e(a_alu_src_b_e), .pc_src_e(a_pc_src_e), .reg_write_e(a_reg_write_e),
        .result_src_e(a_result_src_e), .rd_e(a_rd_e), .mem_write_m(a_mem_write_m),
        .funct3_m(a_funct3_m), .reg_write_m(a_reg_write_m), .rd_m(a_rd_m),
        .reg_write_w(a_reg_write_w), .result_src_w(a_result_src_w), .rd_w(a_rd_w)
`ifdef RV_CTRL_ILLEGAL_EN
        , .illegal_w(a_illegal_w)
`endif
    );

    rv_pipe_control #(.EXTRA_MEM_STAGES(2)) u_dut2 (
        .clk(clk), .reset(reset), .instr_d(instr_d), .flush_e(flush_e),
        .zero_e(zero_e), .less_than_e(less_than_e), .less_than_u_e(less_than_u_e),
        .imm_src_d(b_imm_src_d), .alu_control_e(b_alu_control_e), .alu_src_a_e(b_alu_src_a_e),
        .alu_src_b_e(b_alu_src_b_e), .pc_src_e(b_pc_src_e), .reg_write_e(b_reg_write_e),
        .result_src_e(b_result_src_e), .rd_e(b_rd_e), .mem_write_m(b_mem_write_m),
        .funct3_m(b_funct3_m), .reg_write_m(b_reg_write_m), .rd_m(b_rd_m),
        .reg_write_w(b_reg_write_w), .result_src_w(b_result_src_w), .rd_w(b_rd_w)
`ifdef RV_CTRL_ILLEGAL_EN
        , .illegal_w(b_illegal_w)
`endif
    );

    // kind: 0 plain, 1 jal, 2 jalr, 3 branch
    typedef struct packed {
        logic       rw;
        logic [1:0] res;
        logic       mw;
        logic [2:0] f3;
        logic [3:0] alu;
        logic [1:0] sa;
        logic       sb;
        logic [4:0] rd;
        logic [1:0] kind;
        logic       ill;
    } mexp_t;

    // hist[k] = bundle that was in Execute k cycles ago
    mexp_t hist [0:7];

    function automatic mexp_t model_decode(input logic [31:0] ins);
        mexp_t      e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       lui, auipc, jal, jalr, br, ld, st, opi, opr, legal;
        logic [3:0] alu_tbl [0:7];
        alu_tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        e = '0;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        lui = (op == 7'h37); auipc = (op == 7'h17); jal = (op == 7'h6F); jalr = (op == 7'h67);
        br = (op == 7'h63); ld = (op == 7'h03); st = (op == 7'h23); opi = (op == 7'h13); opr = (op == 7'h33);
        legal = lui | auipc | jal | jalr | br | ld | st | opi | opr;
        if (br && (f3 == 3'd2 || f3 == 3'd3)) legal = 1'b0;
        if (opr && !(f7 == 7'h00 || f7 == 7'h20)) legal = 1'b0;
        if (!legal) begin
            e.ill = 1'b1;
            return e;
        end
        e.rw  = !(br || st);
        e.mw  = st;
        e.res = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
        e.rd  = e.rw ? ins[11:7] : 5'd0;
        e.f3  = (br || ld || st) ? f3 : 3'd0;
        if (opr || opi) begin
            e.alu = alu_tbl[f3];
            if (opr && f3 == 3'd0 && ins[30]) e.alu = 4'd1;
            if (f3 == 3'd5 && ins[30]) e.alu = 4'd9;
        end else if (br) begin
            e.alu = 4'd1;
        end
        e.sa   = lui ? 2'd2 : (auipc ? 2'd1 : 2'd0);
        e.sb   = !(opr || br || jal);
        e.kind = jal ? 2'd1 : (jalr ? 2'd2 : (br ? 2'd3 : 2'd0));
        return e;
    endfunction

    function automatic logic [2:0] model_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'h23:        return 3'd1;
            7'h63:        return 3'd2;
            7'h6F:        return 3'd3;
            7'h37, 7'h17: return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] model_pc(input mexp_t e, input logic z, input logic lt, input logic ltu);
        logic take;
        if (e.kind == 2'd1) return 2'd1;
        if (e.kind == 2'd2) return 2'd2;
        if (e.kind != 2'd3) return 2'd0;
        case (e.f3)
            3'd0:    take = z;
            3'd1:    take = !z;
            3'd4:    take = lt;
            3'd5:    take = !lt;
            3'd6:    take = ltu;
            3'd7:    take = !ltu;
            default: take = 1'b0;
        endcase
        return take ? 2'd1 : 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 8; k++) hist[k] = '0;
    endtask

    task automatic check_all();
        mexp_t e, m, w0, w2;
        logic [1:0] pc;
        e = hist[0]; m = hist[1]; w0 = hist[2]; w2 = hist[4];
        pc = model_pc(e, zero_e, less_than_e, less_than_u_e);
        chk("a_imm_src_d", a_imm_src_d, model_imm(instr_d));
        chk("b_imm_src_d", b_imm_src_d, model_imm(instr_d));
        chk("a_alu_control_e", a_alu_control_e, e.alu);
        chk("b_alu_control_e", b_alu_control_e, e.alu);
        chk("a_alu_src_a_e", a_alu_src_a_e, e.sa);
        chk("a_alu_src_b_e", a_alu_src_b_e, e.sb);
        chk("a_pc_src_e", a_pc_src_e, pc);
        chk("b_pc_src_e", b_pc_src_e, pc);
        chk("a_reg_write_e", a_reg_write_e, e.rw);
        chk("a_result_src_e", a_result_src_e, e.res);
        chk("a_rd_e", a_rd_e, e.rd);
        chk("b_rd_e", b_rd_e, e.rd);
        chk("a_mem_write_m", a_mem_write_m, m.mw);
        chk("b_mem_write_m", b_mem_write_m, m.mw);
        chk("a_funct3_m", a_funct3_m, m.f3);
        chk("a_reg_write_m", a_reg_write_m, m.rw);
        chk("a_rd_m", a_rd_m, m.rd);
        chk("b_rd_m", b_rd_m, m.rd);
        chk("a_reg_write_w", a_reg_write_w, w0.rw);
        chk("a_result_src_w", a_result_src_w, w0.res);
        chk("a_rd_w", a_rd_w, w0.rd);
        chk("b_reg_write_w", b_reg_write_w, w2.rw);
        chk("b_result_src_w", b_result_src_w, w2.res);
        chk("b_rd_w", b_rd_w, w2.rd);
`ifdef RV_CTRL_ILLEGAL_EN
        chk("a_illegal_w", a_illegal_w, w0.ill);
        chk("b_illegal_w", b_illegal_w, w2.ill);
`endif
    endtask

    // Advance one clock: update the model at the edge, drive new inputs, check at the falling edge
    task automatic tick(input logic [31:0] ins, input logic fl, input logic rs,
                        input logic z, input logic lt, input logic ltu);
        @(posedge clk);
        if (reset) begin
            clear_model();
        end else begin
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = flush_e ? mexp_t'('0) : model_decode(instr_d);
        end
        #1;
        instr_d = ins; flush_e = fl; zero_e = z; less_than_e = lt; less_than_u_e = ltu;
        if (rs) clear_model();
        reset = rs;
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [0:8];
        int          r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        ins = $urandom;
        r = $urandom_range(0, 11);
        if (r <= 8) begin
            ins[6:0] = ops[r];
            if (r == 8 && $urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            if (r == 7 && $urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end else if (r == 10) begin
            ins = 32'h0;
        end
        return ins;
    endfunction

    localparam logic [31:0] ADDI_X1_5 = 32'h00500093;
    localparam logic [31:0] BEQ       = 32'h00208463;
    localparam logic [31:0] BLTU      = 32'h0020E463;
    localparam logic [31:0] JALR_X1   = 32'h000100E7;
    localparam logic [31:0] LW_X5     = 32'h00032283;
    localparam logic [31:0] SW        = 32'h00112023;
    localparam logic [31:0] ADD_X3    = 32'h002081B3;

    initial begin
        reset = 1'b1; instr_d = ADDI_X1_5; flush_e = 1'b0;
        zero_e = 1'b0; less_than_e = 1'b0; less_than_u_e = 1'b0;
        clear_model();

        // reset holds every stage at a bubble
        @(negedge clk);
        check_all();
        tick(ADDI_X1_5, 0, 1, 0, 0, 0);
        chk("rst_rd_e", a_rd_e, 0);
        chk("rst_reg_write_w", a_reg_write_w, 0);
        tick(ADDI_X1_5, 0, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("addi_rd_e", a_rd_e, 1);
        tick(32'h0, 0, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("addi_reg_write_w", a_reg_write_w, 1);
        chk("addi_rd_w", a_rd_w, 1);

        // branches
        tick(BEQ, 0, 0, 0, 0, 0);
        tick(BEQ, 0, 0, 1, 0, 0);
        chk("beq_taken", a_pc_src_e, 2'b01);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("beq_not_taken", a_pc_src_e, 2'b00);
        tick(BLTU, 0, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0, 1);
        chk("bltu_taken", a_pc_src_e, 2'b01);

        // jalr
        tick(JALR_X1, 0, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("jalr_pc_src", a_pc_src_e, 2'b10);
        tick(32'h0, 0, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("jalr_result_src_w", a_result_src_w, 2'b10);
        chk("jalr_rd_w", a_rd_w, 1);

        // load then flushed follower
        tick(LW_X5, 0, 0, 0, 0, 0);
        tick(ADDI_X1_5, 1, 0, 0, 0, 0);
        chk("lw_result_src_e", a_result_src_e, 2'b01);
        chk("lw_rd_e", a_rd_e, 5);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("flush_reg_write_e", a_reg_write_e, 0);
        chk("flush_rd_e", a_rd_e, 0);

        // store then add through the two extra memory stages
        tick(SW, 0, 0, 0, 0, 0);
        tick(ADD_X3, 0, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("sw_mem_write_m", b_mem_write_m, 1);
        tick(32'h0, 0, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("sw_rd_w", b_rd_w, 0);
        chk("sw_reg_write_w", b_reg_write_w, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("add_reg_write_w", b_reg_write_w, 1);
        chk("add_rd_w", b_rd_w, 3);

`ifdef RV_CTRL_ILLEGAL_EN
        tick(32'hFFFFFFFF, 0, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("ill_early", a_illegal_w, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("ill_w", a_illegal_w, 1);
        chk("ill_reg_write_w", a_reg_write_w, 0);
        tick(32'h0, 0, 0, 0, 0, 0);
        chk("ill_pulse_end", a_illegal_w, 0);
`endif

        // randomized traffic with flushes, occasional resets and random flags
        repeat (3000) begin
            tick(rand_instr(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
